// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int unsigned SUB_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_e;

    // Bit-counter width for an operand of w bits.
    function automatic int unsigned cnt_w(input int unsigned w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/fs_bit_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bin, with borrow out.
module fs_bit_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock LSB-first,
// with a start/done handshake and registered results.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    sub_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;

    logic cell_d;
    logic cell_bo;

    fs_bit_cell u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    amsb_d  = a[WIDTH-1];
                    bmsb_d  = b[WIDTH-1];
                end
            end
            SHIFT: begin
                res_d = {cell_d, res_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = cell_bo;
                cnt_d = cnt_q + CW'(1);
                // Last bit: publish the completed result so diff never shows partial shifts.
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    diff_d  = res_d;
                    bout_d  = cell_bo;
                    ovf_d   = (amsb_q != bmsb_q) && (cell_d != amsb_q);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int checks;
    int errors;
    logic [W-1:0] prev_diff;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic         bi;
        logic [W-1:0] ed;
        logic         eb;
        logic         eo;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One full operation: accept at E0, expect done in the cycle after E_W.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic bi, input logic [W-1:0] ed, input logic eb, input logic eo);
        int k;
        @(negedge clk);
        a = av; b = bv; bin = bi; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
        k = 0;
        while (done !== 1'b1 && k < W + 4) begin
            @(negedge clk);
            k++;
            if (k == W / 2) chk({tag, "_diff_hold"}, 32'(diff), 32'(prev_diff));
        end
        chk({tag, "_latency"}, 32'(k), 32'(W));
        chk({tag, "_diff"}, 32'(diff), 32'(ed));
        chk({tag, "_bout"}, 32'(bout), 32'(eb));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_diff_kept"}, 32'(diff), 32'(ed));
        prev_diff = ed;
    endtask

    initial begin
        int k;
        int pulses;
        int pulse_at;

        checks    = 0;
        errors    = 0;
        prev_diff = '0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 1'b1};
        vecs[7] = '{8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[8] = '{8'h10, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_ovf",  32'(ovf),  32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].av, vecs[i].bv, vecs[i].bi,
                   vecs[i].ed, vecs[i].eb, vecs[i].eo);
        end

        // start pulsed at E3 during SHIFT must be ignored
        @(negedge clk);
        a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 0; pulses = 0; pulse_at = -1;
        while (k < W + 5) begin
            if (k == 2) begin
                a = 8'hFF; b = 8'h00; bin = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
            if (done === 1'b1) begin
                pulses++;
                if (pulse_at < 0) pulse_at = k;
            end
            if (k == W / 2) chk("ign_diff_hold", 32'(diff), 32'(prev_diff));
        end
        chk("ign_pulses", 32'(pulses), 32'd1);
        chk("ign_latency", 32'(pulse_at), 32'(W));
        chk("ign_diff", 32'(diff), 32'h02);
        chk("ign_bout", 32'(bout), 32'd0);
        chk("ign_busy_end", 32'(busy), 32'd0);
        prev_diff = 8'h02;

        // reset asserted at E4 mid-operation
        @(negedge clk);
        a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_diff", 32'(diff), 32'd0);
        chk("mrst_bout", 32'(bout), 32'd0);
        chk("mrst_ovf",  32'(ovf),  32'd0);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        chk("mrst_no_done", 32'(pulses), 32'd0);
        chk("mrst_idle", 32'(busy), 32'd0);
        prev_diff = '0;
        run_op("post_rst", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
